math_expr_issuer: RTL and testbench

Initiator side of the math_expression start/valid protocol.
- Accepts operand sets {a,b,c,d} from an upstream valid/ready source and issues one-cycle start pulses to math_expression.
- Tracks in-flight requests, captures each valid/q/rmd result into an ordered result FIFO, and presents the results downstream with valid/ready.
- Credit-based issue guarantees the result FIFO never overflows. A watchdog flags a responder that never answers.

---
 rtl/math_expr_issuer_if.sv | 67 ++++++
 rtl/math_expr_issuer.sv | 240 ++++++++++++++++++++++++
 tb/tb_math_expr_issuer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/math_expr_issuer_if.sv
// math_expr_issuer_if: upstream operand, math_expression and downstream result
// signals of the issuer, with status. The master modport is the issuer side.
// Build macro MATH_EXPR_ISSUER_CHECK_EN adds the mismatch_cnt signal.
interface math_expr_issuer_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned OW = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_a;
    logic signed [W-1:0]  in_b;
    logic signed [W-1:0]  in_c;
    logic signed [W-1:0]  in_d;

    logic                 me_start;
    logic signed [W-1:0]  me_a;
    logic signed [W-1:0]  me_b;
    logic signed [W-1:0]  me_c;
    logic signed [W-1:0]  me_d;
    logic                 me_valid;
    logic signed [W-1:0]  me_q;
    logic                 me_rmd;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  out_q;
    logic                 out_rmd;

    logic                 busy;
    logic [OW-1:0]        outstanding;
    logic                 timeout_err;
    logic                 spurious_err;
    logic                 clear_err;
`ifdef MATH_EXPR_ISSUER_CHECK_EN
    logic [7:0]           mismatch_cnt;
`endif

    modport master (
`ifdef MATH_EXPR_ISSUER_CHECK_EN
        output mismatch_cnt,
`endif
        input  in_valid, in_a, in_b, in_c, in_d,
        output in_ready,
        output me_start, me_a, me_b, me_c, me_d,
        input  me_valid, me_q, me_rmd,
        output out_valid, out_q, out_rmd,
        input  out_ready,
        output busy, outstanding, timeout_err, spurious_err,
        input  clear_err
    );

    modport slave (
`ifdef MATH_EXPR_ISSUER_CHECK_EN
        input  mismatch_cnt,
`endif
        output in_valid, in_a, in_b, in_c, in_d,
        input  in_ready,
        input  me_start, me_a, me_b, me_c, me_d,
        output me_valid, me_q, me_rmd,
        input  out_valid, out_q, out_rmd,
        output out_ready,
        input  busy, outstanding, timeout_err, spurious_err,
        output clear_err
    );
endinterface

// File: rtl/math_expr_issuer.sv
// math_expr_issuer: issues operand sets to math_expression, buffers results in
// order with credit-based flow control, and watches for a silent responder.
// Build macro MATH_EXPR_ISSUER_CHECK_EN adds a shadow-operand result checker.
module math_expr_issuer #(
    parameter int unsigned W       = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    math_expr_issuer_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          outs_q, outs_d;
    logic [OW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [DEPTH-1:0][W:0]  mem_q, mem_d;
    logic [W:0]             head_q, head_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   me_start_q, me_start_d;
    logic signed [W-1:0]    me_a_q, me_a_d, me_b_q, me_b_d;
    logic signed [W-1:0]    me_c_q, me_c_d, me_d_q, me_d_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   spurious_err_q, spurious_err_d;

    logic                   in_ready_c;
    logic                   accept, resp, spur, pop, timeout_hit, fault_clear;
    logic [OW:0]            credit_used;

    // Credit check: in-flight plus buffered results may never exceed the FIFO depth
    assign credit_used = (OW+1)'(outs_q) + (OW+1)'(cnt_q);
    assign in_ready_c  = (state_q != FAULT) && (credit_used < (OW+1)'(DEPTH));
    assign accept      = bus.in_valid && in_ready_c;
    assign resp        = bus.me_valid && (outs_q != '0);
    assign spur        = bus.me_valid && (outs_q == '0);
    assign pop         = (cnt_q != '0) && bus.out_ready;
    assign fault_clear = (state_q == FAULT) && bus.clear_err;

    // Next-state, counters, result FIFO and issue registers
    always_comb begin
        state_d        = state_q;
        outs_d         = outs_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        mem_d          = mem_q;
        head_d         = head_q;
        timer_d        = timer_q;
        me_start_d     = accept;
        me_a_d         = me_a_q;
        me_b_d         = me_b_q;
        me_c_d         = me_c_q;
        me_d_d         = me_d_q;
        timeout_err_d  = timeout_err_q;
        spurious_err_d = spurious_err_q;
        timeout_hit    = 1'b0;

        if (accept) begin
            me_a_d = bus.in_a;
            me_b_d = bus.in_b;
            me_c_d = bus.in_c;
            me_d_d = bus.in_d;
        end

        outs_d = outs_q + OW'(accept) - OW'(resp);

        if (resp) begin
            mem_d[wr_q] = {bus.me_rmd, bus.me_q};
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + OW'(resp) - OW'(pop);
        // Head register tracks the oldest entry; it holds when the FIFO drains
        if (cnt_d != '0) begin
            head_d = mem_d[rd_d];
        end

        if ((outs_q == '0) || bus.me_valid) begin
            timer_d = '0;
        end else if (state_q != FAULT) begin
            timer_d = timer_q + TW'(1);
        end
        timeout_hit = (state_q == ACTIVE) && (timer_d == TW'(TIMEOUT));

        unique case (state_q)
            IDLE:    if (accept) state_d = ACTIVE;
            ACTIVE: begin
                if (timeout_hit)        state_d = FAULT;
                else if (outs_d == '0)  state_d = IDLE;
            end
            FAULT:   if (bus.clear_err) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fault_clear) begin
            outs_d  = '0;
            timer_d = '0;
        end

        if (bus.clear_err) begin
            timeout_err_d  = 1'b0;
            spurious_err_d = 1'b0;
        end
        if (timeout_hit) timeout_err_d  = 1'b1;
        if (spur)        spurious_err_d = 1'b1;
    end

    assign out_valid_d = (cnt_d != '0);
    assign busy_d      = (state_d == ACTIVE);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            outs_q         <= '0;
            cnt_q          <= '0;
            rd_q           <= '0;
            wr_q           <= '0;
            mem_q          <= '0;
            head_q         <= '0;
            timer_q        <= '0;
            me_start_q     <= 1'b0;
            me_a_q         <= '0;
            me_b_q         <= '0;
            me_c_q         <= '0;
            me_d_q         <= '0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            spurious_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            outs_q         <= outs_d;
            cnt_q          <= cnt_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            mem_q          <= mem_d;
            head_q         <= head_d;
            timer_q        <= timer_d;
            me_start_q     <= me_start_d;
            me_a_q         <= me_a_d;
            me_b_q         <= me_b_d;
            me_c_q         <= me_c_d;
            me_d_q         <= me_d_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            spurious_err_q <= spurious_err_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.me_start     = me_start_q;
    assign bus.me_a         = me_a_q;
    assign bus.me_b         = me_b_q;
    assign bus.me_c         = me_c_q;
    assign bus.me_d         = me_d_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_q        = head_q[W-1:0];
    assign bus.out_rmd      = head_q[W];
    assign bus.busy         = busy_q;
    assign bus.outstanding  = outs_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.spurious_err = spurious_err_q;

`ifdef MATH_EXPR_ISSUER_CHECK_EN
    localparam int unsigned SW = 4 * W;

    logic [DEPTH-1:0][SW-1:0] sh_q, sh_d;
    logic [AW-1:0]            sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;
    logic [7:0]               mismatch_cnt_q, mismatch_cnt_d;
    logic signed [W-1:0]      ck_a, ck_b, ck_c, ck_d;
    logic signed [W-1:0]      ck_diff, ck_mul, ck_prod, ck_sum, ck_exp;

    // Expected quotient of the oldest outstanding operand set, compared on each counted response
    always_comb begin
        sh_d           = sh_q;
        sh_rd_d        = sh_rd_q;
        sh_wr_d        = sh_wr_q;
        mismatch_cnt_d = mismatch_cnt_q;

        ck_a    = sh_q[sh_rd_q][SW-1 -: W];
        ck_b    = sh_q[sh_rd_q][3*W-1 -: W];
        ck_c    = sh_q[sh_rd_q][2*W-1 -: W];
        ck_d    = sh_q[sh_rd_q][W-1:0];
        ck_diff = W'(ck_a - ck_b);
        ck_mul  = W'(1 + 3 * ck_c);
        ck_prod = W'(ck_diff * ck_mul);
        ck_sum  = W'(ck_prod - 4 * ck_d);
        ck_exp  = W'(ck_sum / 2);

        if (accept) begin
            sh_d[sh_wr_q] = {bus.in_a, bus.in_b, bus.in_c, bus.in_d};
            sh_wr_d       = sh_wr_q + AW'(1);
        end
        if (resp) begin
            sh_rd_d = sh_rd_q + AW'(1);
            if ((ck_exp != bus.me_q) && (mismatch_cnt_q != 8'hFF)) begin
                mismatch_cnt_d = mismatch_cnt_q + 8'd1;
            end
        end
        // Abandoned requests are dropped together with the outstanding count
        if (fault_clear) begin
            sh_rd_d = '0;
            sh_wr_d = '0;
        end
    end

    // Shadow operand FIFO and mismatch counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q           <= '0;
            sh_rd_q        <= '0;
            sh_wr_q        <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            sh_q           <= sh_d;
            sh_rd_q        <= sh_rd_d;
            sh_wr_q        <= sh_wr_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign bus.mismatch_cnt = mismatch_cnt_q;
`endif
endmodule

// File: tb/tb_math_expr_issuer.sv
// tb_math_expr_issuer: scoreboard bench with a latency-3 math_expression model.
module tb_math_expr_issuer;
    localparam int unsigned W       = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        shortint q;
        logic    rmd;
    } res_t;

    typedef enum int {R_AUTO, R_BAD, R_OFF} rmode_t;

    logic   clk = 1'b0;
    logic   reset;
    rmode_t rmode = R_AUTO;
    logic   hold = 1'b0;
    int     spur_req = 0;
    int     spur_done = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    res_t   sb[$];

    always #5 clk = ~clk;

    math_expr_issuer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    math_expr_issuer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic res_t model(input shortint a, input shortint b, input shortint c, input shortint d);
        shortint x, y, p, s;
        res_t    r;
        x     = shortint'(int'(a) - int'(b));
        y     = shortint'(1 + 3 * int'(c));
        p     = shortint'(int'(x) * int'(y));
        s     = shortint'(int'(p) - 4 * int'(d));
        r.q   = shortint'(int'(s) / 2);
        r.rmd = (int'(s) % 2) != 0;
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Responder model: answers each start three cycles later, in order
    initial begin
        res_t r;
        res_t pend[$];
        int   due[$];
        int   cyc;
        cyc          = 0;
        bus.me_valid = 1'b0;
        bus.me_q     = '0;
        bus.me_rmd   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.me_valid = 1'b0;
            if (reset !== 1'b1) begin
                pend.delete();
                due.delete();
            end else begin
                if (bus.me_start && rmode != R_OFF) begin
                    r = model(bus.me_a, bus.me_b, bus.me_c, bus.me_d);
                    if (rmode == R_BAD) r.q = shortint'(r.q + 1);
                    pend.push_back(r);
                    due.push_back(cyc + 2);
                end
                if (spur_req != spur_done) begin
                    spur_done++;
                    bus.me_valid = 1'b1;
                    bus.me_q     = 16'sd7;
                    bus.me_rmd   = 1'b0;
                end else if (!hold && pend.size() > 0 && due[0] <= cyc) begin
                    r = pend.pop_front();
                    void'(due.pop_front());
                    bus.me_valid = 1'b1;
                    bus.me_q     = r.q;
                    bus.me_rmd   = r.rmd;
                end
            end
        end
    end

    // Output monitor: every pop is compared against the scoreboard head
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1 && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("out_q", bus.out_q, e.q);
                    check("out_rmd", bus.out_rmd, e.rmd);
                end
            end
        end
    end

    task automatic send(input shortint a, input shortint b, input shortint c, input shortint d, input bit expect_out);
        res_t e;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_d     = d;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                if (expect_out) begin
                    e = model(a, b, c, d);
                    if (rmode == R_BAD) e.q = shortint'(e.q + 1);
                    sb.push_back(e);
                end
                tick();
                bus.in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("send_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !bus.out_valid && bus.outstanding == 0) break;
            tick();
        end
        check("drain_sb", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic seen;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.in_d      = '0;
        bus.out_ready = 1'b1;
        bus.clear_err = 1'b0;
        tick(2);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_me_start", bus.me_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_outstanding", bus.outstanding, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        check("rst_spurious_err", bus.spurious_err, 0);
        check("rst_out_q", bus.out_q, 0);
        reset = 1'b1;
        tick();
        check("rel_in_ready", bus.in_ready, 1);

        // Single transaction with issue-latency and result checks
        send(-4, 6, -2, 1, 1'b1);
        check("t1_me_start", bus.me_start, 1);
        check("t1_me_a", bus.me_a, -4);
        check("t1_me_b", bus.me_b, 6);
        check("t1_me_c", bus.me_c, -2);
        check("t1_me_d", bus.me_d, 1);
        check("t1_outstanding", bus.outstanding, 1);
        check("t1_busy", bus.busy, 1);
        tick();
        check("t1_start_pulse", bus.me_start, 0);
        check("t1_me_a_hold", bus.me_a, -4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            if (bus.me_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t1_me_valid_seen", seen, 1);
        tick();
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_q", bus.out_q, 23);
        tick();
        check("t1_out_drained", bus.out_valid, 0);
        check("t1_outstanding_0", bus.outstanding, 0);
        check("t1_idle", bus.busy, 0);

        // Credit limit: four fill the FIFO, the fifth waits for pops
        bus.out_ready = 1'b0;
        send(-4, 6, -2, 1, 1'b1);
        send(3, 3, -3, 3, 1'b1);
        send(5, 3, 2, -1, 1'b1);
        send(0, 0, 0, 0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'sd1;
        bus.in_b     = 16'sd2;
        bus.in_c     = 16'sd3;
        bus.in_d     = 16'sd4;
        seen         = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | bus.in_ready;
            tick();
        end
        check("t2_full_in_ready", seen, 0);
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_outstanding", bus.outstanding, 0);
        check("t2_head_q", bus.out_q, 23);
        bus.out_ready = 1'b1;
        send(1, 2, 3, 4, 1'b1);
        wait_drain();

        // Silent responder trips the watchdog exactly TIMEOUT cycles after the start
        rmode = R_OFF;
        send(2, 1, 0, 0, 1'b0);
        tick(TIMEOUT - 1);
        check("t3_pre_timeout", bus.timeout_err, 0);
        tick();
        check("t3_timeout_err", bus.timeout_err, 1);
        check("t3_fault_in_ready", bus.in_ready, 0);
        check("t3_fault_busy", bus.busy, 0);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        check("t3_clr_outstanding", bus.outstanding, 0);
        check("t3_clr_in_ready", bus.in_ready, 1);
        check("t3_clr_timeout_err", bus.timeout_err, 0);
        check("t3_clr_busy", bus.busy, 0);
        rmode = R_AUTO;

        // Response with nothing outstanding
        spur_req++;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (spur_done == spur_req) break;
        end
        tick();
        check("t4_spurious_err", bus.spurious_err, 1);
        check("t4_out_valid", bus.out_valid, 0);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        check("t4_clr_spurious", bus.spurious_err, 0);

        // Asynchronous reset with two in flight and one buffered
        bus.out_ready = 1'b0;
        send(-4, 6, -2, 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) break;
            tick();
        end
        hold = 1'b1;
        send(3, 3, -3, 3, 1'b1);
        send(5, 3, 2, -1, 1'b1);
        check("t5_pre_outstanding", bus.outstanding, 2);
        check("t5_pre_out_valid", bus.out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_out_valid", bus.out_valid, 0);
        check("t5_async_me_start", bus.me_start, 0);
        check("t5_async_outstanding", bus.outstanding, 0);
        check("t5_async_busy", bus.busy, 0);
        sb.delete();
        tick(2);
        reset = 1'b1;
        hold  = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick(5);
        check("t5_post_out_valid", bus.out_valid, 0);
        check("t5_post_me_start", bus.me_start, 0);
        check("t5_post_outstanding", bus.outstanding, 0);
        check("t5_post_in_ready", bus.in_ready, 1);
        send(5, 3, 2, -1, 1'b1);
        wait_drain();

`ifdef MATH_EXPR_ISSUER_CHECK_EN
        // Result checker counts a wrong quotient only
        check("t6_mm_start", bus.mismatch_cnt, 0);
        rmode = R_BAD;
        send(-4, 6, -2, 1, 1'b1);
        wait_drain();
        check("t6_mm_bad", bus.mismatch_cnt, 1);
        rmode = R_AUTO;
        send(-4, 6, -2, 1, 1'b1);
        wait_drain();
        check("t6_mm_good", bus.mismatch_cnt, 1);
`endif

        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
